// File: rtl/clock_meter_if.sv
// Start/done handshake and result bus of the clock meter.
interface clock_meter_if #(parameter int CNT_W = 16);
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  modport master (output start, input busy, done, timeout, period, high_time);
  modport slave  (input start, output busy, done, timeout, period, high_time);
endinterface

// File: rtl/clock_meter.sv
// Measures period and high time of probe_in in clock_in cycles.
// CLOCK_METER_CONTINUOUS_EN: chain measurements back to back after the first start.
module clock_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          probe_in,
  clock_meter_if.slave  bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   s, rise_det, fall_det;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt, wait_cnt, period_q, high_q;
  logic                   done_q, timeout_q;
  logic                   start_acc, to_hit;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], probe_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise_det = s & ~s_d;
  assign fall_det = ~s & s_d;

  // the done cycle is still part of the transaction, so start is refused there
  assign start_acc = bus.start && (state == IDLE) && !done_q;
  assign to_hit    = ((state == ARM) || (state == MEASURE)) &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wait_cnt  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            state     <= ARM;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
          end
        end
        ARM, MEASURE: begin
          wait_cnt <= wait_cnt + 1'b1;
          cnt      <= cnt + 1'b1;
          if (to_hit) begin
            period_q  <= '1;
            high_q    <= '1;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= IDLE;
          end else if (state == ARM) begin
            if (rise_det) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end
          end else begin
            if (fall_det) high_q <= cnt;
            if (rise_det) begin
              period_q <= cnt;
              done_q   <= 1'b1;
`ifdef CLOCK_METER_CONTINUOUS_EN
              // terminating edge opens the next period
              cnt      <= CNT_W'(1);
              wait_cnt <= '0;
              state    <= MEASURE;
`else
              state    <= IDLE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE) | done_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.period    = period_q;
  assign bus.high_time = high_q;
endmodule

// File: tb/tb_clock_meter.sv
// Scoreboard bench for clock_meter: stimulus queues expected results, monitor checks on done.
`timescale 1ns/1ps
module tb_clock_meter;
  localparam int TO = 100;

  logic clock_in, reset_n, probe_in;
  clock_meter_if #(.CNT_W(16)) bus ();

  clock_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .probe_in(probe_in), .bus(bus.slave)
  );

  typedef struct {
    logic        to;
    logic [15:0] per;
    logic [15:0] ht_min;
    logic [15:0] ht_max;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  int   gen_p = 4, gen_h = 2;

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  always @(posedge clock_in) cyc++;

  // probe pattern in half-cycle units: gen_h high out of gen_p
  initial begin
    int ph;
    ph = 0;
    probe_in = 1'b0;
    forever begin
      @(clock_in);
      #1;
      if (ph >= gen_p) ph = 0;
      probe_in = (ph < gen_h);
      ph++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock_in) begin
    exp_t e;
    if (reset_n && bus.done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 want none at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("timeout", {31'd0, bus.timeout}, {31'd0, e.to});
        chk("period", {16'd0, bus.period}, {16'd0, e.per});
        checks++;
        if (bus.high_time < e.ht_min || bus.high_time > e.ht_max) begin
          errors++;
          $display("FAIL high_time got %0d want %0d..%0d", bus.high_time, e.ht_min, e.ht_max);
        end
      end
    end
  end

  int acc_cyc;

  task automatic pulse_start();
    @(negedge clock_in);
    bus.start = 1'b1;
    @(posedge clock_in);
    #1 acc_cyc = cyc;
    @(negedge clock_in);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int dc);
    int n;
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (!bus.done && n < max);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL wait_done got no done want done within %0d cycles", max);
    end
    dc = cyc;
  endtask

  task automatic push(input logic to, input int per, input int lo, input int hi);
    exp_t e;
    e.to = to; e.per = 16'(per); e.ht_min = 16'(lo); e.ht_max = 16'(hi);
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    sbq.delete();
    @(negedge clock_in);
    reset_n = 1'b1;
  endtask

  initial begin
    int dc, dprev, ht0, nd;
    bus.start = 1'b0;
    reset_n   = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_timeout", {31'd0, bus.timeout}, 0);
    chk("rst_period", {16'd0, bus.period}, 0);
    chk("rst_high", {16'd0, bus.high_time}, 0);
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (3) @(negedge clock_in);

`ifdef CLOCK_METER_CONTINUOUS_EN
    gen_p = 10; gen_h = 4;
    repeat (10) @(negedge clock_in);
    for (int k = 0; k < 6; k++) push(1'b0, 5, 2, 2);
    pulse_start();
    wait_done(60, dprev);
    chk("cont_busy0", {31'd0, bus.busy}, 1);
    for (int k = 1; k < 6; k++) begin
      wait_done(20, dc);
      chk("cont_interval", dc - dprev, 5);
      chk("cont_busy", {31'd0, bus.busy}, 1);
      dprev = dc;
    end
    do_reset();
    gen_h = 0;
    repeat (5) @(negedge clock_in);
    push(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    pulse_start();
    wait_done(TO + 10, dc);
    chk("cont_to_latency", dc - acc_cyc, TO);
    @(negedge clock_in);
    chk("cont_to_idle", {31'd0, bus.busy}, 0);
`else
    // probe = clock_in/2
    gen_p = 4; gen_h = 2;
    repeat (5) @(negedge clock_in);
    push(1'b0, 2, 1, 1);
    pulse_start();
    wait_done(60, dc);
    // /3 high one cycle
    gen_p = 6; gen_h = 2;
    repeat (5) @(negedge clock_in);
    push(1'b0, 3, 1, 1);
    pulse_start();
    wait_done(60, dc);
    // /3 at 50% with half-cycle edges
    gen_p = 6; gen_h = 3;
    repeat (5) @(negedge clock_in);
    ht0 = 0;
    for (int r = 0; r < 4; r++) begin
      push(1'b0, 3, 1, 2);
      pulse_start();
      wait_done(60, dc);
      if (r == 0) ht0 = int'(bus.high_time);
      else chk("ht_stable", {16'd0, bus.high_time}, ht0);
      repeat (3) @(negedge clock_in);
    end
    // probe held low -> timeout
    gen_h = 0;
    repeat (5) @(negedge clock_in);
    push(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    pulse_start();
    chk("busy_after_start", {31'd0, bus.busy}, 1);
    wait_done(TO + 10, dc);
    chk("to_latency", dc - acc_cyc, TO);
    // restart clears timeout; second start during busy ignored
    gen_p = 4; gen_h = 2;
    repeat (5) @(negedge clock_in);
    push(1'b0, 2, 1, 1);
    pulse_start();
    chk("timeout_cleared", {31'd0, bus.timeout}, 0);
    nd = done_cnt;
    bus.start = 1'b1;
    @(negedge clock_in);
    bus.start = 1'b0;
    wait_done(60, dc);
    repeat (20) @(negedge clock_in);
    chk("single_done", done_cnt - nd, 1);
    // reset mid-measurement
    gen_p = 40; gen_h = 10;
    repeat (5) @(negedge clock_in);
    pulse_start();
    nd = done_cnt;
    repeat (15) @(negedge clock_in);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_done", {31'd0, bus.done}, 0);
    chk("mid_rst_period", {16'd0, bus.period}, 0);
    chk("mid_rst_high", {16'd0, bus.high_time}, 0);
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (60) @(negedge clock_in);
    chk("no_done_after_rst", done_cnt - nd, 0);
    gen_p = 6; gen_h = 2;
    repeat (5) @(negedge clock_in);
    push(1'b0, 3, 1, 1);
    pulse_start();
    wait_done(60, dc);
`endif
    repeat (5) @(negedge clock_in);
    chk("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
